uart_bluetooth_tx: RTL and testbench

- 8N1 UART transmitter for the Bluetooth serial link; the return direction of the car's command receive path.
- Sends status/telemetry bytes from the car back to the phone over the same Bluetooth UART module.
- Small byte FIFO decouples producers using a valid/ready handshake from the bit-serial line.
- Includes a baud-rate counter and a framing state machine.

---
 rtl/uart_bt_pkg.sv | 14 +
 rtl/uart_bluetooth_tx_if.sv | 11 +
 rtl/bt_tx_fifo.sv | 52 +++++
 rtl/uart_bluetooth_tx.sv | 129 ++++++++++++
 tb/tb_uart_bluetooth_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bt_pkg.sv
// Shared definitions for the Bluetooth UART link (tx and rx agree on baud and framing).
package uart_bt_pkg;
   localparam int unsigned DATA_W               = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;

   typedef logic [DATA_W-1:0] tx_data_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/uart_bluetooth_tx_if.sv
// Valid/ready byte handshake between a telemetry producer and the UART transmitter.
interface uart_bluetooth_tx_if;
   import uart_bt_pkg::*;

   tx_data_t tx_byte;
   logic     tx_valid;
   logic     tx_ready;

   modport master (output tx_byte, output tx_valid, input tx_ready);
   modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/bt_tx_fifo.sv
// Small circular byte FIFO; push/pop are ignored when full/empty respectively.
module bt_tx_fifo
   import uart_bt_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FIFO_AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  tx_data_t         din,
   output tx_data_t         dout,
   output logic [FIFO_AW:0] count,
   output logic             full,
   output logic             empty
);
   localparam int unsigned CNT_W = FIFO_AW + 1;

   tx_data_t           mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wptr;
   logic [FIFO_AW-1:0] rptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + FIFO_AW'(1);
         if (pop_ok)  rptr <= rptr + FIFO_AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end
endmodule

// File: rtl/uart_bluetooth_tx.sv
// 8N1 UART transmitter returning car status bytes to the phone over the Bluetooth module.
module uart_bluetooth_tx
   import uart_bt_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic                clk,
   input  logic                rst,
   uart_bluetooth_tx_if.slave  tx,
   output logic                serial,
   output logic                busy,
   output logic                overflow
);
   localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   tx_data_t          shift_q, shift_d;
   logic              serial_d;
   logic              pop;
   logic              ready;
   logic              baud_end;
   tx_data_t          head;
   logic [FIFO_AW:0]  count;
   logic              full;
   logic              empty;

   bt_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx.tx_valid & ready),
      .pop   (pop),
      .din   (tx.tx_byte),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign ready       = ~full;
   assign tx.tx_ready = ready;
   assign busy        = (state_q != S_IDLE) | (count != '0);
   assign baud_end    = (baud_q == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         serial  <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         serial  <= serial_d;
      end
   end

   // Framing: serial_d is the line level for the cycle after this edge.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      serial_d = serial;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = head;
               baud_d   = '0;
               serial_d = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d   = '0;
               bit_d    = '0;
               serial_d = shift_q[0];
               state_d  = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  serial_d = 1'b1;
                  state_d  = S_STOP;
               end else begin
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
                  bit_d    = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky until reset: a producer pushed while the queue was full.
   always_ff @(posedge clk) begin
      if (rst)                        overflow <= 1'b0;
      else if (tx.tx_valid && !ready) overflow <= 1'b1;
   end
endmodule

// File: tb/tb_uart_bluetooth_tx.sv
// Directed bench for uart_bluetooth_tx at 4 clocks per bit with an independent line decoder.
module tb_uart_bluetooth_tx;
   import uart_bt_pkg::*;

   localparam int unsigned K = 4;

   logic clk = 1'b0;
   logic rst;
   logic serial;
   logic busy;
   logic overflow;

   uart_bluetooth_tx_if bus ();

   uart_bluetooth_tx #(
      .CLKS_PER_BIT (K),
      .FIFO_DEPTH   (4),
      .FIFO_AW      (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx       (bus),
      .serial   (serial),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      tick();
      check(name, 32'(busy), 32'd0);
   endtask

   // Line decoder: samples each bit mid-period on the falling clock edge.
   logic [9:0] mon_frame;
   int         mon_cnt = 0;
   bit         mon_active = 1'b0;
   int         gap = 0;
   logic [9:0] frames[$];
   int         gaps[$];

   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
         gap        = 0;
      end else if (mon_active) begin
         if (mon_cnt % K == K / 2) mon_frame[mon_cnt / K] = serial;
         if (mon_cnt == 10 * K - 1) begin
            mon_active = 1'b0;
            frames.push_back(mon_frame);
            gap = 0;
         end
         mon_cnt++;
      end else if (serial === 1'b0) begin
         mon_active = 1'b1;
         mon_cnt    = 1;
         gaps.push_back(gap);
      end else begin
         gap++;
      end
   end

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      int         busy_cyc;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] wb[10];

   initial begin
      logic [7:0] b;
      logic       exp_s;
      int         cyc;
      int         low_cnt;
      int         ff_cnt;

      vecs[0] = '{8'hA3, 10'b1_10100011_0, 41};
      vecs[1] = '{8'h00, 10'b1_00000000_0, 41};
      vecs[2] = '{8'hFF, 10'b1_11111111_0, 41};
      vecs[3] = '{8'h5A, 10'b1_01011010_0, 41};
      wb = '{8'hC1, 8'h3E, 8'h7F, 8'h80, 8'h02, 8'hFD, 8'h99, 8'h66, 8'hAA, 8'h14};

      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'h00;
      rst = 1'b1;
      tick();
      tick();
      check("rst_serial", 32'(serial), 32'd1);
      check("rst_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // Single byte, cycle-exact line and busy timing.
      frames.delete();
      b = 8'h55;
      bus.tx_byte  = b;
      bus.tx_valid = 1'b1;
      check("t1_ready_pre", 32'(bus.tx_ready), 32'd1);
      tick();
      bus.tx_valid = 1'b0;
      check("t1_serial_n0", 32'(serial), 32'd1);
      for (int k = 1; k <= 44; k++) begin
         tick();
         if (k <= 4)       exp_s = 1'b0;
         else if (k <= 36) exp_s = b[(k - 5) / 4];
         else              exp_s = 1'b1;
         check($sformatf("t1_serial_k%0d", k), 32'(serial), 32'(exp_s));
         check($sformatf("t1_busy_k%0d", k), 32'(busy), (k <= 40) ? 32'd1 : 32'd0);
      end
      check("t1_nframes", 32'(frames.size()), 32'd1);
      check("t1_frame", (frames.size() > 0) ? 32'(frames[0]) : 32'd0, 32'(10'b1_01010101_0));

      // Table of single-byte frames.
      for (int i = 0; i < 4; i++) begin
         frames.delete();
         bus.tx_byte  = vecs[i].data;
         bus.tx_valid = 1'b1;
         tick();
         bus.tx_valid = 1'b0;
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (busy === 1'b1 && cyc < 200);
         check($sformatf("vec%0d_busy_cyc", i), 32'(cyc), 32'(vecs[i].busy_cyc));
         check($sformatf("vec%0d_nframes", i), 32'(frames.size()), 32'd1);
         check($sformatf("vec%0d_frame", i), (frames.size() > 0) ? 32'(frames[0]) : 32'd0,
               32'(vecs[i].frame));
         tick();
      end

      // Back-to-back: five consecutive accepts, first pop overlaps the second push.
      frames.delete();
      gaps.delete();
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.tx_byte = 8'(i + 1);
         check($sformatf("t3_ready_acc%0d", i), 32'(bus.tx_ready), 32'd1);
         tick();
      end
      bus.tx_valid = 1'b0;
      check("t3_ready_full", 32'(bus.tx_ready), 32'd0);
      wait_idle("t3_idle");
      check("t3_nframes", 32'(frames.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_byte%0d", i), (frames.size() > i) ? 32'(frames[i][8:1]) : 32'hdead,
               32'(i + 1));
      end
      for (int i = 1; i < 5; i++) begin
         check($sformatf("t3_gap%0d", i), (gaps.size() > i) ? 32'(gaps[i]) : 32'hdead, 32'd1);
      end

      // Overflow: queue full during a frame, then 0xFF offered while not ready.
      frames.delete();
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.tx_byte = 8'(8'h10 + i);
         tick();
      end
      check("t4_ready_full", 32'(bus.tx_ready), 32'd0);
      check("t4_ovf_pre", 32'(overflow), 32'd0);
      bus.tx_byte = 8'hFF;
      for (int i = 0; i < 8; i++) tick();
      bus.tx_valid = 1'b0;
      check("t4_ovf_set", 32'(overflow), 32'd1);
      wait_idle("t4_idle");
      check("t4_ovf_sticky", 32'(overflow), 32'd1);
      check("t4_nframes", 32'(frames.size()), 32'd5);
      ff_cnt = 0;
      for (int i = 0; i < frames.size(); i++) begin
         if (frames[i][8:1] == 8'hFF) ff_cnt++;
         if (i < 5) check($sformatf("t4_byte%0d", i), 32'(frames[i][8:1]), 32'(8'h10 + i));
      end
      check("t4_no_ff", 32'(ff_cnt), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 32'd0);
      tick();

      // Reset during data bit 3 with two bytes queued.
      frames.delete();
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.tx_byte = 8'(8'h21 + i);
         tick();
      end
      bus.tx_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check("t5_bit3", 32'(serial), 32'd0);
      check("t5_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_serial", 32'(serial), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_ready", 32'(bus.tx_ready), 32'd1);
      check("t5_ovf", 32'(overflow), 32'd0);
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (serial !== 1'b1) low_cnt++;
      end
      check("t5_line_quiet", 32'(low_cnt), 32'd0);
      check("t5_nframes", 32'(frames.size()), 32'd0);

      // Pointer wrap: ten bytes pushed in pairs.
      frames.delete();
      for (int p = 0; p < 5; p++) begin
         bus.tx_valid = 1'b1;
         bus.tx_byte  = wb[2 * p];
         tick();
         bus.tx_byte  = wb[2 * p + 1];
         tick();
         bus.tx_valid = 1'b0;
         wait_idle($sformatf("t6_idle%0d", p));
      end
      check("t6_nframes", 32'(frames.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t6_byte%0d", i), (frames.size() > i) ? 32'(frames[i][8:1]) : 32'hdead,
               32'(wb[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
